// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches over req/ack and holds the returned instruction and its PC for decode.
// Latency: first valid instruction on the 2nd edge after reset release; one instruction per 2 cycles with a zero-wait memory.
// Backpressure: Stall_i holds the instruction in WAIT; optional misaligned-redirect fault when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  Mem_Req_o,
    output logic [DATA_WIDTH-1:0] Mem_Addr_o,
    input  logic                  Mem_Ack_i,
    input  logic [DATA_WIDTH-1:0] Mem_Rdata_i,
    input  logic                  Stall_i,
    input  logic                  Redirect_i,
    input  logic [DATA_WIDTH-1:0] Redirect_PC_i,
    output logic                  Instr_Valid_o,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic [DATA_WIDTH-1:0] PC_o,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic [6:0]            OP_o,
    output logic                  Fault_o
`else
    output logic [6:0]            OP_o
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        FLUSH = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [DATA_WIDTH-1:0] WORD_MASK = ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
    localparam logic [DATA_WIDTH-1:0] PC_STEP   = {{(DATA_WIDTH-3){1'b0}}, 3'd4};

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;          // next PC to fetch (redirect target once redirected)
    logic [DATA_WIDTH-1:0] addr_q, addr_d;      // address on the bus; keeps the outstanding address while flushing
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                  vld_q, vld_d;
    logic                  req_q, req_d;
    logic                  pend_q, pend_d;      // flush must end in FAULT (misaligned target seen)
    logic [DATA_WIDTH-1:0] redir_tgt;
    logic                  redir_mis;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign redir_tgt = Redirect_PC_i;
    assign redir_mis = |(Redirect_PC_i & ~WORD_MASK);
`else
    // Without the check, low target bits are simply dropped.
    assign redir_tgt = Redirect_PC_i & WORD_MASK;
    assign redir_mis = 1'b0;
`endif

    // Next-state and output computation for the fetch FSM.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        vld_d    = vld_q;
        pend_d   = pend_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (Redirect_i) begin
                    pc_d = redir_tgt;
                    if (Mem_Ack_i) begin
                        // Returned data belongs to the wrong path; drop it.
                        if (redir_mis) begin
                            state_d = FAULT;
                        end else begin
                            addr_d = redir_tgt;
                        end
                    end else begin
                        // Bus address must stay put until memory acks.
                        state_d = FLUSH;
                        pend_d  = redir_mis;
                    end
                end else if (Mem_Ack_i) begin
                    instr_d  = Mem_Rdata_i;
                    pc_out_d = pc_q;
                    vld_d    = 1'b1;
                    pc_d     = pc_q + PC_STEP;
                    addr_d   = pc_q + PC_STEP;
                    state_d  = WAIT;
                end
            end
            FLUSH: begin
                if (Redirect_i) begin
                    pc_d   = redir_tgt;
                    pend_d = redir_mis;
                end
                if (Mem_Ack_i) begin
                    if (Redirect_i ? redir_mis : pend_q) begin
                        state_d = FAULT;
                    end else begin
                        addr_d  = Redirect_i ? redir_tgt : pc_q;
                        state_d = FETCH;
                    end
                end
            end
            WAIT: begin
                if (Redirect_i) begin
                    vld_d   = 1'b0;
                    instr_d = NOP_INSTR;
                    pc_d    = redir_tgt;
                    if (redir_mis) begin
                        state_d = FAULT;
                    end else begin
                        addr_d  = redir_tgt;
                        state_d = FETCH;
                    end
                end else if (!Stall_i) begin
                    vld_d   = 1'b0;
                    instr_d = NOP_INSTR;
                    state_d = FETCH;
                end
            end
            default: begin
                // FAULT: terminal until reset.
                vld_d = 1'b0;
            end
        endcase
        req_d = (state_d == FETCH) || (state_d == FLUSH);
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = (state_d == FAULT);
`endif
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            instr_q  <= NOP_INSTR;
            pc_out_q <= '0;
            vld_q    <= 1'b0;
            req_q    <= 1'b0;
            pend_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            vld_q    <= vld_d;
            req_q    <= req_d;
            pend_q   <= pend_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= fault_d;
`endif
        end
    end

    assign Mem_Req_o     = req_q;
    assign Mem_Addr_o    = addr_q;
    assign Instr_Valid_o = vld_q;
    assign Instr_o       = instr_q;
    assign PC_o          = pc_out_q;
    assign OP_o          = instr_q[6:0];
`ifdef FETCH_ALIGN_CHECK_EN
    assign Fault_o       = fault_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus randomized traffic.
// Outputs are compared against a transaction-level model every cycle at the falling edge.
// Covers FETCH_ALIGN_CHECK_EN both defined and undefined.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0040_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        Mem_Req_o;
    logic [31:0] Mem_Addr_o;
    logic        Mem_Ack_i;
    logic [31:0] Mem_Rdata_i;
    logic        Stall_i;
    logic        Redirect_i;
    logic [31:0] Redirect_PC_i;
    logic        Instr_Valid_o;
    logic [31:0] Instr_o;
    logic [31:0] PC_o;
    logic [6:0]  OP_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        Fault_o;
`endif

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .Mem_Req_o     (Mem_Req_o),
        .Mem_Addr_o    (Mem_Addr_o),
        .Mem_Ack_i     (Mem_Ack_i),
        .Mem_Rdata_i   (Mem_Rdata_i),
        .Stall_i       (Stall_i),
        .Redirect_i    (Redirect_i),
        .Redirect_PC_i (Redirect_PC_i),
        .Instr_Valid_o (Instr_Valid_o),
        .Instr_o       (Instr_o),
        .PC_o          (PC_o),
`ifdef FETCH_ALIGN_CHECK_EN
        .OP_o          (OP_o),
        .Fault_o       (Fault_o)
`else
        .OP_o          (OP_o)
`endif
    );

    always #5 clk = ~clk;

    // Transaction-level model: what the bus and the holding register must show.
    logic        m_started;   // first edge after reset release seen
    logic        m_req;       // request on the bus
    logic        m_discard;   // outstanding request is stale (redirected away)
    logic        m_pend;      // stale request must end in a fault
    logic        m_fault;
    logic [31:0] m_addr;
    logic [31:0] m_next;      // next address to fetch
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_req = 1'b0; m_discard = 1'b0; m_pend = 1'b0; m_fault = 1'b0;
        m_addr = RPC; m_next = RPC; m_valid = 1'b0; m_instr = NOP; m_pc = 32'h0;
    endtask

    task automatic enter_fault();
        m_fault = 1'b1; m_req = 1'b0; m_valid = 1'b0; m_instr = NOP; m_discard = 1'b0;
    endtask

    // Apply one rising edge worth of rules using the currently driven inputs.
    task automatic model_step();
        logic [31:0] t;
        logic        mis;
`ifdef FETCH_ALIGN_CHECK_EN
        t   = Redirect_PC_i;
        mis = (Redirect_PC_i % 4) != 0;
`else
        t   = Redirect_PC_i - (Redirect_PC_i % 4);
        mis = 1'b0;
`endif
        if (!m_started) begin
            m_started = 1'b1; m_req = 1'b1; m_addr = m_next;
        end else if (m_fault) begin
            m_req = 1'b0;
        end else if (m_req && m_discard) begin
            if (Redirect_i) begin m_next = t; m_pend = mis; end
            if (Mem_Ack_i) begin
                m_discard = 1'b0;
                if (m_pend) enter_fault(); else m_addr = m_next;
            end
        end else if (m_req) begin
            if (Redirect_i) begin
                m_next = t;
                if (Mem_Ack_i) begin
                    if (mis) enter_fault(); else m_addr = t;
                end else begin
                    m_discard = 1'b1; m_pend = mis;
                end
            end else if (Mem_Ack_i) begin
                m_valid = 1'b1; m_instr = Mem_Rdata_i; m_pc = m_addr;
                m_next = m_addr + 32'd4; m_addr = m_next; m_req = 1'b0;
            end
        end else if (m_valid) begin
            if (Redirect_i) begin
                m_valid = 1'b0; m_instr = NOP; m_next = t;
                if (mis) enter_fault(); else begin m_req = 1'b1; m_addr = t; end
            end else if (!Stall_i) begin
                m_valid = 1'b0; m_instr = NOP; m_req = 1'b1; m_addr = m_next;
            end
        end
    endtask

    task automatic compare_all();
        chk("req",   {31'b0, Mem_Req_o},     {31'b0, m_req});
        chk("addr",  Mem_Addr_o,             m_addr);
        chk("valid", {31'b0, Instr_Valid_o}, {31'b0, m_valid});
        chk("instr", Instr_o,                m_instr);
        chk("pc",    PC_o,                   m_pc);
        chk("op",    {25'b0, OP_o},          {25'b0, m_instr[6:0]});
`ifdef FETCH_ALIGN_CHECK_EN
        chk("fault", {31'b0, Fault_o},       {31'b0, m_fault});
`endif
    endtask

    // Drive one cycle of inputs, advance the model, then check at the next falling edge.
    task automatic cycle(input logic rst, input logic ack, input logic [31:0] rd,
                         input logic st, input logic rdr, input logic [31:0] tgt);
        reset = rst; Mem_Ack_i = ack; Mem_Rdata_i = rd; Stall_i = st;
        Redirect_i = rdr; Redirect_PC_i = tgt;
        if (rst) begin
            model_reset();
            #1 compare_all();
        end else begin
            model_step();
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        // Reset state
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_req",   {31'b0, Mem_Req_o}, 32'h0);
        chk("rst_addr",  Mem_Addr_o, 32'h0040_0000);
        chk("rst_valid", {31'b0, Instr_Valid_o}, 32'h0);
        chk("rst_instr", Instr_o, 32'h0000_0013);
        chk("rst_pc",    PC_o, 32'h0);

        // Zero-wait memory: fetch, hold, fetch next
        cycle(0, 1, 32'h00A0_0093, 0, 0, 0);
        chk("z_req1",  {31'b0, Mem_Req_o}, 32'h1);
        chk("z_addr1", Mem_Addr_o, 32'h0040_0000);
        cycle(0, 1, 32'h00A0_0093, 0, 0, 0);
        chk("z_valid1", {31'b0, Instr_Valid_o}, 32'h1);
        chk("z_pc1",    PC_o, 32'h0040_0000);
        chk("z_op1",    {25'b0, OP_o}, 32'h13);
        chk("z_instr1", Instr_o, 32'h00A0_0093);
        cycle(0, 1, 32'h00A0_0093, 0, 0, 0);
        chk("z_valid_gap", {31'b0, Instr_Valid_o}, 32'h0);
        chk("z_addr2",     Mem_Addr_o, 32'h0040_0004);
        cycle(0, 1, 32'h0010_0113, 0, 0, 0);
        chk("z_pc2", PC_o, 32'h0040_0004);

        // Stall holds the instruction for 3 cycles
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 32'hFFFF_FFFF, 1, 0, 0);
            chk("st_instr", Instr_o, 32'h0010_0113);
            chk("st_req",   {31'b0, Mem_Req_o}, 32'h0);
        end
        cycle(0, 0, 0, 0, 0, 0);
        chk("st_next_addr", Mem_Addr_o, 32'h0040_0008);
        chk("st_next_req",  {31'b0, Mem_Req_o}, 32'h1);

        // Delayed ack with redirect while waiting
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0040_0100);
        chk("fl_addr_hold", Mem_Addr_o, 32'h0040_0008);
        cycle(0, 0, 0, 0, 0, 0);
        chk("fl_addr_hold2", Mem_Addr_o, 32'h0040_0008);
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        chk("fl_dropped", {31'b0, Instr_Valid_o}, 32'h0);
        chk("fl_new_addr", Mem_Addr_o, 32'h0040_0100);
        cycle(0, 1, 32'h0050_0113, 0, 0, 0);
        chk("fl_pc", PC_o, 32'h0040_0100);

        // Redirect beats stall in WAIT
        cycle(0, 0, 0, 1, 1, 32'h0040_0200);
        chk("rs_valid", {31'b0, Instr_Valid_o}, 32'h0);
        chk("rs_instr", Instr_o, 32'h0000_0013);
        chk("rs_addr",  Mem_Addr_o, 32'h0040_0200);

        // PC wraps past the top of the address space
        cycle(0, 1, 0, 0, 1, 32'hFFFF_FFFC);
        chk("wr_addr", Mem_Addr_o, 32'hFFFF_FFFC);
        cycle(0, 1, 32'h0000_0033, 0, 0, 0);
        chk("wr_pc", PC_o, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0, 0, 0);
        chk("wr_next", Mem_Addr_o, 32'h0000_0000);

        // Reset mid-request with a late ack
        reset = 1'b1; Mem_Ack_i = 1'b1;
        #1;
        chk("mr_req",   {31'b0, Mem_Req_o}, 32'h0);
        chk("mr_addr",  Mem_Addr_o, 32'h0040_0000);
        chk("mr_valid", {31'b0, Instr_Valid_o}, 32'h0);
        cycle(1, 1, 32'h1234_5678, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("mr_first", Mem_Addr_o, 32'h0040_0000);

        // Misaligned redirect
        cycle(0, 1, 0, 0, 1, 32'h0040_0102);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'b0, Fault_o}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 0, 1, 32'h0040_0300);
            chk("mis_hold_req", {31'b0, Mem_Req_o}, 32'h0);
            chk("mis_hold_flt", {31'b0, Fault_o}, 32'h1);
        end
        cycle(1, 0, 0, 0, 0, 0);
        chk("mis_rst_flt", {31'b0, Fault_o}, 32'h0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h0040_0102);
        chk("mis_fl_addr", Mem_Addr_o, 32'h0040_0000);
        chk("mis_fl_flt",  {31'b0, Fault_o}, 32'h0);
        cycle(0, 1, 0, 0, 0, 0);
        chk("mis_fl_fault", {31'b0, Fault_o}, 32'h1);
        chk("mis_fl_req",   {31'b0, Mem_Req_o}, 32'h0);
`else
        chk("mis_addr", Mem_Addr_o, 32'h0040_0100);
        chk("mis_req",  {31'b0, Mem_Req_o}, 32'h1);
`endif

        // Randomized traffic
        cycle(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            tgt[1:0] = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cycle($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, tgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
